// File: rtl/dev_rx_getc.sv
// -----------------------------------------------------------------------------
// dev_rx_getc
//   CPU-side "getc" engine for the UART receive pipe. It serves one read
//   request at a time and pops at most one byte from the front of the receive
//   FIFO. Blocking reads can wait forever or for a bounded number of cycles.
//   Non-blocking reads return EMPTY at once. A popped byte that matches the
//   end-of-transmission code can be reported as EOF.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req        : read request, sampled only while idle
//   nonblock   : sampled with req; 1 = return EMPTY when there is no data
//   rd_ack     : one-cycle pulse; rd_data/rd_status are valid
//   rd_data    : byte read; 0 for EMPTY and TIMEOUT completions
//   rd_status  : 0 OK, 1 EMPTY, 2 TIMEOUT, 3 EOF
//   busy       : high whenever a request is in progress
//   fifo_empty : receive FIFO empty flag
//   fifo_data  : FIFO front element, valid while fifo_empty = 0
//   fifo_pop   : pop_front strobe, registered, one cycle wide
//   pop_count  : bytes popped since reset, wraps silently
// -----------------------------------------------------------------------------
module dev_rx_getc #(
  parameter int                DATA_W         = 8,
  parameter int                TIMEOUT_CYCLES = 0,
  parameter bit                EOT_EN         = 1'b1,
  parameter logic [DATA_W-1:0] EOT_CHAR       = 'h04,
  parameter int                CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              nonblock,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        rd_status,
  output logic              busy,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_pop,
  output logic [CNT_W-1:0]  pop_count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_POP, S_DONE} state_t;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_EMPTY   = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_EOF     = 2'd3;

  // Timeout counter only has to reach TIMEOUT_CYCLES-1.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  // Set when the current request really popped a byte. A non-blocking empty
  // read also passes through S_POP, so every immediate completion acks two
  // cycles after the request. This flag keeps that pass from counting or
  // reclassifying anything.
  logic          got_byte;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tmo_cnt   <= '0;
      got_byte  <= 1'b0;
      rd_ack    <= 1'b0;
      rd_data   <= '0;
      rd_status <= ST_OK;
      fifo_pop  <= 1'b0;
      pop_count <= '0;
    end else begin
      rd_ack   <= 1'b0;
      fifo_pop <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            if (!fifo_empty) begin
              rd_data  <= fifo_data;
              fifo_pop <= 1'b1;
              got_byte <= 1'b1;
              state    <= S_POP;
            end else if (nonblock) begin
              rd_data   <= '0;
              rd_status <= ST_EMPTY;
              got_byte  <= 1'b0;
              state     <= S_POP;
            end else begin
              tmo_cnt <= '0;
              state   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Data arriving in the same cycle the timeout expires wins.
          if (!fifo_empty) begin
            rd_data  <= fifo_data;
            fifo_pop <= 1'b1;
            got_byte <= 1'b1;
            state    <= S_POP;
          end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
            rd_data   <= '0;
            rd_status <= ST_TIMEOUT;
            rd_ack    <= 1'b1;
            state     <= S_DONE;
          end else if (TMO_EN) begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_POP: begin
          // fifo_empty settles during this cycle, so a request that follows
          // cannot pop the same entry twice.
          if (got_byte) begin
            pop_count <= pop_count + CNT_W'(1);
            rd_status <= (EOT_EN && (rd_data == EOT_CHAR)) ? ST_EOF : ST_OK;
          end
          rd_ack <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
